// File: rtl/stack_pkg.sv
// stack_pkg: opcodes and per-op stack requirements for stack_alu.
// op_req() gives legality, minimum entry count and stack growth.
package stack_pkg;

    localparam logic [3:0] OP_PUSH  = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_DUP   = 4'd2;
    localparam logic [3:0] OP_SWAP  = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_CLEAR = 4'd10;

    typedef struct packed {
        logic       legal;
        logic [1:0] need;
        logic       grow;
    } op_req_t;

    function automatic op_req_t op_req(input logic [3:0] op);
        op_req_t r;
        r = '{legal: 1'b1, need: 2'd0, grow: 1'b0};
        case (op)
            OP_PUSH:  r.grow = 1'b1;
            OP_POP:   r.need = 2'd1;
            OP_DUP: begin
                r.need = 2'd1;
                r.grow = 1'b1;
            end
            OP_SWAP, OP_ADD, OP_SUB,
            OP_AND, OP_OR, OP_XOR: r.need = 2'd2;
            OP_NOT:   r.need = 2'd1;
            OP_CLEAR: r.need = 2'd0;
            default:  r.legal = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/stack_mem.sv
// stack_mem: storage for the entries below top-of-stack plus the size pointer.
// Ports: clk, rst (async low), we_i/wsel_i/wdata_i write, sp_d_i next size, sp_o size, s_o second entry.
module stack_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int SW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wsel_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [SW-1:0] sp_d_i,
    output logic [SW-1:0] sp_o,
    output logic [W-1:0]  s_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [SW-1:0] sp_q;
    logic [SW-1:0] a_push;
    logic [SW-1:0] a_sec;
    logic [AW-1:0] waddr;

    // Entry i of the logical stack lives at mem[i]; top (index sp-1) is
    // held outside, so the slot at sp-1 is where the old top spills on
    // growth and sp-2 is the second entry.
    assign a_push = sp_q - SW'(1);
    assign a_sec  = sp_q - SW'(2);
    assign waddr  = wsel_i ? a_sec[AW-1:0] : a_push[AW-1:0];
    assign s_o    = mem_q[a_sec[AW-1:0]];
    assign sp_o   = sp_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d_i;
        end
    end

endmodule

// File: rtl/stack_alu.sv
// stack_alu: LIFO of W-bit entries with an ALU working on the top two.
// Ports: clk, rst (async low), in, op, apply -> head, empty, full, size, valid.
module stack_alu
    import stack_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int SW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  in,
    input  logic [3:0]    op,
    input  logic          apply,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic          full,
    output logic [SW-1:0] size,
    output logic          valid
);

    op_req_t       req;
    logic          accept;
    logic [W-1:0]  top_q, top_d;
    logic          valid_q;
    logic [SW-1:0] sp_q, sp_d;
    logic [W-1:0]  s_val;
    logic          we;
    logic          wsel;
    logic [W-1:0]  wdata;

    stack_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .SW    (SW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .wsel_i  (wsel),
        .wdata_i (wdata),
        .sp_d_i  (sp_d),
        .sp_o    (sp_q),
        .s_o     (s_val)
    );

    assign empty = (sp_q == '0);
    assign full  = (sp_q == SW'(DEPTH));
    assign size  = sp_q;
    assign head  = top_q;
    assign valid = valid_q;

    assign req    = op_req(op);
    assign accept = req.legal
                  && (sp_q >= SW'(req.need))
                  && !(req.grow && full);

    always_comb begin
        top_d = top_q;
        sp_d  = sp_q;
        we    = 1'b0;
        wsel  = 1'b0;
        wdata = top_q;
        if (apply && accept) begin
            case (op)
                OP_PUSH: begin
                    // old top spills to memory only if there was one
                    we    = !empty;
                    top_d = in;
                    sp_d  = sp_q + SW'(1);
                end
                OP_POP: begin
                    top_d = (sp_q == SW'(1)) ? '0 : s_val;
                    sp_d  = sp_q - SW'(1);
                end
                OP_DUP: begin
                    we   = 1'b1;
                    sp_d = sp_q + SW'(1);
                end
                OP_SWAP: begin
                    we    = 1'b1;
                    wsel  = 1'b1;
                    top_d = s_val;
                end
                OP_ADD: begin
                    top_d = s_val + top_q;
                    sp_d  = sp_q - SW'(1);
                end
                OP_SUB: begin
                    top_d = s_val - top_q;
                    sp_d  = sp_q - SW'(1);
                end
                OP_AND: begin
                    top_d = s_val & top_q;
                    sp_d  = sp_q - SW'(1);
                end
                OP_OR: begin
                    top_d = s_val | top_q;
                    sp_d  = sp_q - SW'(1);
                end
                OP_XOR: begin
                    top_d = s_val ^ top_q;
                    sp_d  = sp_q - SW'(1);
                end
                OP_NOT: top_d = ~top_q;
                OP_CLEAR: begin
                    top_d = '0;
                    sp_d  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            top_q   <= '0;
            valid_q <= 1'b1;
        end else if (apply) begin
            top_q   <= top_d;
            valid_q <= accept;
        end
    end

endmodule

// File: tb/tb_stack_alu.sv
// tb_stack_alu: directed checks of stack_alu at W=8, DEPTH=4.
// Each test task drives ops and compares outputs with hand-computed values.
module tb_stack_alu;
    import stack_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [3:0] op;
    logic       apply;
    logic [7:0] head;
    logic       empty;
    logic       full;
    logic [2:0] size;
    logic       valid;

    int checks;
    int failures;

    stack_alu #(
        .W     (8),
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .in    (din),
        .op    (op),
        .apply (apply),
        .head  (head),
        .empty (empty),
        .full  (full),
        .size  (size),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [3:0] o, input logic [7:0] d);
        @(negedge clk);
        op    = o;
        din   = d;
        apply = 1'b1;
        @(posedge clk);
        #1;
        apply = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1;
        checks++;
        if (head !== 8'd0 || size !== 3'd0 || empty !== 1'b1
            || full !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: head=%0d size=%0d empty=%b full=%b valid=%b, want 0 0 1 0 1",
                     head, size, empty, full, valid);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(OP_POP, 8'd0);
        checks++;
        if (valid !== 1'b0 || empty !== 1'b1 || size !== 3'd0 || head !== 8'd0) begin
            failures++;
            $display("FAIL pop_empty: valid=%b empty=%b size=%0d head=%0d, want 0 1 0 0",
                     valid, empty, size, head);
        end
    endtask

    task automatic test_sub_wrap;
        do_op(OP_PUSH, 8'd22);
        do_op(OP_PUSH, 8'd5);
        do_op(OP_SUB, 8'd0);
        checks++;
        if (head !== 8'd17 || size !== 3'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL sub: head=%0d size=%0d valid=%b, want 17 1 1", head, size, valid);
        end
        do_op(OP_PUSH, 8'd20);
        do_op(OP_SUB, 8'd0);
        checks++;
        if (head !== 8'd253 || size !== 3'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL sub_wrap: head=%0d size=%0d valid=%b, want 253 1 1", head, size, valid);
        end
        do_op(OP_CLEAR, 8'd0);
        checks++;
        if (head !== 8'd0 || size !== 3'd0 || empty !== 1'b1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL clear: head=%0d size=%0d empty=%b valid=%b, want 0 0 1 1",
                     head, size, empty, valid);
        end
    endtask

    task automatic test_full;
        for (int i = 1; i <= 4; i++) begin
            do_op(OP_PUSH, 8'(i));
        end
        checks++;
        if (full !== 1'b1 || size !== 3'd4 || head !== 8'd4) begin
            failures++;
            $display("FAIL fill: full=%b size=%0d head=%0d, want 1 4 4", full, size, head);
        end
        do_op(OP_PUSH, 8'd9);
        checks++;
        if (valid !== 1'b0 || head !== 8'd4 || size !== 3'd4) begin
            failures++;
            $display("FAIL push_full: valid=%b head=%0d size=%0d, want 0 4 4", valid, head, size);
        end
        do_op(OP_DUP, 8'd0);
        checks++;
        if (valid !== 1'b0 || head !== 8'd4 || size !== 3'd4) begin
            failures++;
            $display("FAIL dup_full: valid=%b head=%0d size=%0d, want 0 4 4", valid, head, size);
        end
        for (int i = 3; i >= 1; i--) begin
            do_op(OP_POP, 8'd0);
            checks++;
            if (valid !== 1'b1 || head !== 8'(i) || size !== 3'(i) || full !== 1'b0) begin
                failures++;
                $display("FAIL pop_chain%0d: valid=%b head=%0d size=%0d full=%b, want 1 %0d %0d 0",
                         i, valid, head, size, full, i, i);
            end
        end
        do_op(OP_POP, 8'd0);
        checks++;
        if (head !== 8'd0 || empty !== 1'b1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL pop_last: head=%0d empty=%b valid=%b, want 0 1 1", head, empty, valid);
        end
    endtask

    task automatic test_logic;
        do_op(OP_PUSH, 8'h0F);
        do_op(OP_PUSH, 8'hF0);
        do_op(OP_SWAP, 8'd0);
        checks++;
        if (head !== 8'h0F || size !== 3'd2 || valid !== 1'b1) begin
            failures++;
            $display("FAIL swap: head=%h size=%0d valid=%b, want 0f 2 1", head, size, valid);
        end
        do_op(OP_OR, 8'd0);
        checks++;
        if (head !== 8'hFF || size !== 3'd1) begin
            failures++;
            $display("FAIL or: head=%h size=%0d, want ff 1", head, size);
        end
        do_op(OP_NOT, 8'd0);
        checks++;
        if (head !== 8'h00 || size !== 3'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL not: head=%h size=%0d valid=%b, want 00 1 1", head, size, valid);
        end
        do_op(OP_SWAP, 8'd0);
        checks++;
        if (valid !== 1'b0 || head !== 8'h00 || size !== 3'd1) begin
            failures++;
            $display("FAIL swap_one: valid=%b head=%h size=%0d, want 0 00 1", valid, head, size);
        end
    endtask

    task automatic test_reserved_hold;
        do_op(OP_NOT, 8'd0);
        do_op(OP_PUSH, 8'h5A);
        do_op(4'd12, 8'h77);
        checks++;
        if (valid !== 1'b0 || head !== 8'h5A || size !== 3'd2) begin
            failures++;
            $display("FAIL reserved: valid=%b head=%h size=%0d, want 0 5a 2", valid, head, size);
        end
        do_op(OP_POP, 8'd0);
        checks++;
        if (valid !== 1'b1 || head !== 8'hFF || size !== 3'd1) begin
            failures++;
            $display("FAIL pop_after_rsv: valid=%b head=%h size=%0d, want 1 ff 1", valid, head, size);
        end
        op  = OP_CLEAR;
        din = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (valid !== 1'b1 || head !== 8'hFF || size !== 3'd1
                || empty !== 1'b0 || full !== 1'b0) begin
                failures++;
                $display("FAIL hold%0d: valid=%b head=%h size=%0d empty=%b full=%b, want 1 ff 1 0 0",
                         i, valid, head, size, empty, full);
            end
        end
        do_op(4'd15, 8'd0);
        @(posedge clk);
        #1;
        checks++;
        if (valid !== 1'b0 || head !== 8'hFF) begin
            failures++;
            $display("FAIL hold_reject: valid=%b head=%h, want 0 ff", valid, head);
        end
    endtask

    task automatic test_back_to_back;
        do_op(OP_CLEAR, 8'd0);
        do_op(OP_PUSH, 8'h3C);
        do_op(OP_DUP, 8'd0);
        checks++;
        if (head !== 8'h3C || size !== 3'd2 || valid !== 1'b1) begin
            failures++;
            $display("FAIL dup: head=%h size=%0d valid=%b, want 3c 2 1", head, size, valid);
        end
        do_op(OP_XOR, 8'd0);
        checks++;
        if (head !== 8'h00 || size !== 3'd1) begin
            failures++;
            $display("FAIL xor: head=%h size=%0d, want 00 1", head, size);
        end
        do_op(OP_PUSH, 8'hF3);
        do_op(OP_ADD, 8'd0);
        checks++;
        if (head !== 8'hF3 || size !== 3'd1) begin
            failures++;
            $display("FAIL add: head=%h size=%0d, want f3 1", head, size);
        end
        do_op(OP_PUSH, 8'h20);
        do_op(OP_ADD, 8'd0);
        checks++;
        if (head !== 8'h13 || size !== 3'd1) begin
            failures++;
            $display("FAIL add_wrap: head=%h size=%0d, want 13 1", head, size);
        end
        do_op(OP_PUSH, 8'h0F);
        do_op(OP_AND, 8'd0);
        checks++;
        if (head !== 8'h03 || size !== 3'd1) begin
            failures++;
            $display("FAIL and: head=%h size=%0d, want 03 1", head, size);
        end
    endtask

    task automatic test_async_reset;
        do_op(OP_PUSH, 8'd7);
        do_op(OP_PUSH, 8'd8);
        checks++;
        if (head !== 8'd8 || size !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset: head=%0d size=%0d, want 8 3", head, size);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (head !== 8'd0 || size !== 3'd0 || empty !== 1'b1
            || full !== 1'b0 || valid !== 1'b1) begin
            failures++;
            $display("FAIL async_reset: head=%0d size=%0d empty=%b full=%b valid=%b, want 0 0 1 0 1",
                     head, size, empty, full, valid);
        end
        @(negedge clk);
        rst = 1'b1;
        do_op(OP_PUSH, 8'd3);
        checks++;
        if (head !== 8'd3 || size !== 3'd1 || valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_push: head=%0d size=%0d valid=%b, want 3 1 1",
                     head, size, valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst   = 1'b1;
        apply = 1'b0;
        op    = 4'd0;
        din   = 8'd0;
        #2;
        test_reset();
        test_sub_wrap();
        test_full();
        test_logic();
        test_reserved_hold();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
